// File: rtl/and_gate_vector_seq_if.sv
// ---------------------------------------------------------------------------
// and_gate_vector_seq_if
// Bundles the control, gate-stimulus and result signals of the AND-gate
// vector sequencer.
//   master : test controller side (drives start and y_in, observes results)
//   slave  : sequencer side (and_gate_vector_seq)
// Signals
//   start       begin a sweep (sampled only while the sequencer is idle)
//   y_in        output of the gate under test
//   a_out       registered gate input vector
//   busy        sweep in progress
//   done        one-cycle end-of-sweep pulse
//   pass        last sweep had zero mismatches
//   err_count   mismatches in last sweep
//   fail_valid  fail_vec holds a meaningful vector
//   fail_vec    first vector that mismatched
// ---------------------------------------------------------------------------
interface and_gate_vector_seq_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic            y_in;
   logic [N_IN-1:0] a_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            fail_valid;
   logic [N_IN-1:0] fail_vec;

   modport master (
      output start, y_in,
      input  a_out, busy, done, pass, err_count, fail_valid, fail_vec
   );

   modport slave (
      input  start, y_in,
      output a_out, busy, done, pass, err_count, fail_valid, fail_vec
   );
endinterface

// File: rtl/and_gate_vector_seq.sv
// ---------------------------------------------------------------------------
// and_gate_vector_seq
// Exhaustive stimulus/checker for an N_IN-input AND gate. On start it walks
// every input vector 0 .. 2^N_IN-1, holds each for SETTLE_CYC cycles, samples
// the gate output for one cycle and compares it with the reduction-AND of the
// vector. At the end it pulses done and reports error count, first failing
// vector and pass/fail; results persist until the next accepted start.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    and_gate_vector_seq_if.slave (start, y_in in; a_out, busy, done,
//          pass, err_count, fail_valid, fail_vec out)
// Parameters
//   N_IN        number of gate inputs, 1..8
//   SETTLE_CYC  cycles each vector is held before sampling, >= 1
// ---------------------------------------------------------------------------
module and_gate_vector_seq #(
   parameter int N_IN       = 2,
   parameter int SETTLE_CYC = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   and_gate_vector_seq_if.slave  bus
);

   generate
      if (N_IN < 1 || N_IN > 8 || SETTLE_CYC < 1) begin : g_param_err
         $error("and_gate_vector_seq: N_IN must be 1..8 and SETTLE_CYC >= 1");
      end
   endgenerate

   localparam int              CW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]   WAIT_RELOAD = CW'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0] VEC_LAST    = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state;
   logic [N_IN-1:0] vec;
   logic [CW-1:0]   wait_cnt;

   logic [N_IN-1:0] a_out_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [N_IN:0]   err_count_q;
   logic            fail_valid_q;
   logic [N_IN-1:0] fail_vec_q;

   // Golden response of a correct AND gate for the vector being sampled.
   logic mismatch;
   assign mismatch = (bus.y_in != (&vec));

   // NOTE: every register below is written with non-blocking assignments so
   // all state updates on an edge see the pre-edge values of each other.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         vec          <= '0;
         wait_cnt     <= '0;
         a_out_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
      end else begin
         // done is a single-cycle pulse; only the DONE state raises it.
         done_q <= 1'b0;

         case (state)
            S_IDLE: begin
               a_out_q <= '0;
               busy_q  <= 1'b0;
               if (bus.start) begin
                  state        <= S_WAIT;
                  vec          <= '0;
                  wait_cnt     <= WAIT_RELOAD;
                  busy_q       <= 1'b1;
                  err_count_q  <= '0;
                  pass_q       <= 1'b0;
                  fail_valid_q <= 1'b0;
                  fail_vec_q   <= '0;
               end
            end

            S_WAIT: begin
               if (wait_cnt == '0) begin
                  state <= S_SAMPLE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end

            S_SAMPLE: begin
               // Mismatch bookkeeping and the vector advance share this edge;
               // err_count cannot exceed 2^N_IN so it never wraps.
               if (mismatch) begin
                  err_count_q <= err_count_q + 1'b1;
                  if (!fail_valid_q) begin
                     fail_vec_q   <= vec;
                     fail_valid_q <= 1'b1;
                  end
               end
               if (vec == VEC_LAST) begin
                  state  <= S_DONE;
                  busy_q <= 1'b0;
               end else begin
                  vec      <= vec + 1'b1;
                  a_out_q  <= vec + 1'b1;
                  wait_cnt <= WAIT_RELOAD;
                  state    <= S_WAIT;
               end
            end

            S_DONE: begin
               done_q  <= 1'b1;
               pass_q  <= (err_count_q == '0);
               busy_q  <= 1'b0;
               a_out_q <= '0;
               vec     <= '0;
               state   <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.a_out      = a_out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_count_q;
   assign bus.fail_valid = fail_valid_q;
   assign bus.fail_vec   = fail_vec_q;

endmodule
